// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bundle: ID-side redirect/stall controls, program port, IF/ID outputs
interface if_stage_if #(
  parameter int NB_PC   = 32,
  parameter int NB_INST = 32,
  parameter int AW      = 8
);
  logic               i_enable;
  logic               i_stall;
  logic               i_take;
  logic [1:0]         i_select_addr;
  logic [25:0]        i_jump_index;
  logic [NB_PC-1:0]   i_branch_addr;
  logic [NB_PC-1:0]   i_reg_addr;
  logic               i_prog_we;
  logic [AW-1:0]      i_prog_addr;
  logic [NB_INST-1:0] i_prog_data;
  logic [NB_PC-1:0]   o_pc;
  logic [NB_PC-1:0]   o_pc_plus4;
  logic [NB_INST-1:0] o_instr;
  logic               o_valid;
  logic               o_halt;

  modport slave (
    input  i_enable, i_stall, i_take, i_select_addr, i_jump_index,
           i_branch_addr, i_reg_addr, i_prog_we, i_prog_addr, i_prog_data,
    output o_pc, o_pc_plus4, o_instr, o_valid, o_halt
  );

  modport master (
    output i_enable, i_stall, i_take, i_select_addr, i_jump_index,
           i_branch_addr, i_reg_addr, i_prog_we, i_prog_addr, i_prog_data,
    input  o_pc, o_pc_plus4, o_instr, o_valid, o_halt
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch: PC, loadable instruction memory, IF/ID latch, redirects, stall, HALT
module if_stage #(
  parameter int                 NB_PC      = 32,
  parameter int                 NB_INST    = 32,
  parameter int                 IMEM_DEPTH = 256,
  parameter logic [NB_INST-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  if_stage_if.slave   bus
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [NB_INST-1:0] imem [IMEM_DEPTH];

  logic [NB_PC-1:0]   pc_q, pc_d;
  logic [NB_PC-1:0]   pc_plus4_q, pc_plus4_d;
  logic [NB_INST-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               halt_q, halt_d;

  logic [NB_PC-1:0]   seq_pc;
  logic [NB_PC-1:0]   target_raw;
  logic [NB_PC-1:0]   target;
  logic [NB_INST-1:0] fetch_word;

  // Program port is independent of run control; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (bus.i_prog_we) begin
      imem[bus.i_prog_addr] <= bus.i_prog_data;
    end
  end

  assign fetch_word = imem[pc_q[AW+1:2]];
  assign seq_pc     = pc_q + NB_PC'(4);

  always_comb begin
    target_raw = seq_pc;
    case (bus.i_select_addr)
      2'b00:   target_raw = {pc_plus4_q[NB_PC-1:28], bus.i_jump_index, 2'b00};
      2'b01:   target_raw = bus.i_branch_addr;
      2'b10:   target_raw = bus.i_reg_addr;
      default: target_raw = seq_pc;
    endcase
  end

  assign target = target_raw & ~NB_PC'(3);

  // A taken redirect squashes the wrong-path fetch: no delay slot.
  always_comb begin
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    if (bus.i_enable && !bus.i_stall) begin
      if (bus.i_take) begin
        pc_d    = target;
        instr_d = '0;
        valid_d = 1'b0;
      end else if (halt_q) begin
        instr_d = '0;
        valid_d = 1'b0;
      end else if (fetch_word == HALT_WORD) begin
        pc_plus4_d = seq_pc;
        instr_d    = fetch_word;
        valid_d    = 1'b1;
        halt_d     = 1'b1;
      end else begin
        pc_d       = seq_pc;
        pc_plus4_d = seq_pc;
        instr_d    = fetch_word;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
    end
  end

  assign bus.o_pc       = pc_q;
  assign bus.o_pc_plus4 = pc_plus4_q;
  assign bus.o_instr    = instr_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_halt     = halt_q;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage: directed redirect, stall, enable, program-port and HALT vectors
module tb_if_stage;
  localparam int          NB_PC      = 32;
  localparam int          NB_INST    = 32;
  localparam int          IMEM_DEPTH = 256;
  localparam int          AW         = 8;
  localparam logic [31:0] HALT       = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_stage_if #(.NB_PC(NB_PC), .NB_INST(NB_INST), .AW(AW)) bus ();

  if_stage #(
    .NB_PC(NB_PC), .NB_INST(NB_INST), .IMEM_DEPTH(IMEM_DEPTH), .HALT_WORD(HALT)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [97:0] exp_q [$];
  string       name_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  event        mon_tick;

  always @(posedge clk) begin
    #1;
    ->mon_tick;
  end

  always @(mon_tick) begin
    if (exp_q.size() > 0) begin
      logic [97:0] e;
      logic [97:0] a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.o_pc, bus.o_pc_plus4, bus.o_instr, bus.o_valid, bus.o_halt};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got pc=%h pc4=%h instr=%h valid=%b halt=%b, expected pc=%h pc4=%h instr=%h valid=%b halt=%b",
                    nm, a[97:66], a[65:34], a[33:2], a[1], a[0],
                    e[97:66], e[65:34], e[33:2], e[1], e[0]);
    end
  end

  function automatic logic [31:0] w(input int i);
    return 32'h2000_0000 | (32'(i) << 16) | 32'(i);
  endfunction

  task automatic push(input string nm, input logic [31:0] pc, input logic [31:0] p4,
                      input logic [31:0] ins, input logic v, input logic h);
    exp_q.push_back({pc, p4, ins, v, h});
    name_q.push_back(nm);
  endtask

  // Expectation is for the state right after the next rising edge.
  task automatic step(input string nm, input logic [31:0] pc, input logic [31:0] p4,
                      input logic [31:0] ins, input logic v, input logic h);
    push(nm, pc, p4, ins, v, h);
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [1:0] sel);
    bus.i_take        = 1'b1;
    bus.i_select_addr = sel;
  endtask

  initial begin
    bus.i_enable      = 1'b1;
    bus.i_stall       = 1'b0;
    bus.i_take        = 1'b0;
    bus.i_select_addr = 2'b11;
    bus.i_jump_index  = '0;
    bus.i_branch_addr = '0;
    bus.i_reg_addr    = '0;
    bus.i_prog_we     = 1'b0;
    bus.i_prog_addr   = '0;
    bus.i_prog_data   = '0;

    for (int i = 0; i < 32; i++) begin
      bus.i_prog_we   = 1'b1;
      bus.i_prog_addr = AW'(i);
      bus.i_prog_data = w(i);
      step("reset_load", 0, 0, 0, 0, 0);
    end
    bus.i_prog_we = 1'b0;
    rst = 1'b0;

    step("seq0", 32'h4,  32'h4,  w(0), 1, 0);
    step("seq1", 32'h8,  32'h8,  w(1), 1, 0);
    step("seq2", 32'hC,  32'hC,  w(2), 1, 0);
    step("seq3", 32'h10, 32'h10, w(3), 1, 0);

    redirect(2'b00);
    bus.i_jump_index = 26'h10;
    step("jump_bubble", 32'h40, 32'h10, 0, 0, 0);
    bus.i_take = 1'b0;
    step("jump_target", 32'h44, 32'h44, w(16), 1, 0);

    bus.i_stall = 1'b1;
    redirect(2'b01);
    bus.i_branch_addr = 32'h20;
    step("stall_hold0", 32'h44, 32'h44, w(16), 1, 0);
    step("stall_hold1", 32'h44, 32'h44, w(16), 1, 0);
    bus.i_stall = 1'b0;
    step("branch_bubble", 32'h20, 32'h44, 0, 0, 0);
    bus.i_take = 1'b0;
    step("branch_target", 32'h24, 32'h24, w(8), 1, 0);

    redirect(2'b10);
    bus.i_reg_addr = 32'h1F;
    step("jr_misaligned", 32'h1C, 32'h24, 0, 0, 0);
    bus.i_take = 1'b0;
    step("jr_target", 32'h20, 32'h20, w(7), 1, 0);

    redirect(2'b11);
    step("sel_seq_bubble", 32'h24, 32'h20, 0, 0, 0);
    bus.i_take = 1'b0;
    step("sel_seq_target", 32'h28, 32'h28, w(9), 1, 0);

    bus.i_enable = 1'b0;
    for (int i = 0; i < 3; i++) step("enable_hold", 32'h28, 32'h28, w(9), 1, 0);
    bus.i_enable = 1'b1;

    bus.i_prog_we   = 1'b1;
    bus.i_prog_addr = 8'd5;
    bus.i_prog_data = 32'hDEADBEEF;
    step("run_while_write", 32'h2C, 32'h2C, w(10), 1, 0);
    bus.i_prog_we = 1'b0;
    redirect(2'b01);
    bus.i_branch_addr = 32'h10;
    step("back_bubble", 32'h10, 32'h2C, 0, 0, 0);
    bus.i_take = 1'b0;
    step("fetch_0x10", 32'h14, 32'h14, w(4), 1, 0);
    bus.i_prog_we   = 1'b1;
    bus.i_prog_addr = 8'd6;
    bus.i_prog_data = 32'h12345678;
    step("new_word_0x14", 32'h18, 32'h18, 32'hDEADBEEF, 1, 0);
    bus.i_prog_addr = 8'd2;
    bus.i_prog_data = HALT;
    step("write_then_read", 32'h1C, 32'h1C, 32'h12345678, 1, 0);
    bus.i_prog_we = 1'b0;

    redirect(2'b01);
    bus.i_branch_addr = 32'h0;
    step("to_zero_bubble", 32'h0, 32'h1C, 0, 0, 0);
    bus.i_take = 1'b0;
    step("pre_halt0", 32'h4, 32'h4, w(0), 1, 0);
    step("pre_halt1", 32'h8, 32'h8, w(1), 1, 0);
    step("halt_fetch", 32'h8, 32'hC, HALT, 1, 1);
    step("halt_bubble0", 32'h8, 32'hC, 0, 0, 1);
    step("halt_bubble1", 32'h8, 32'hC, 0, 0, 1);

    rst = 1'b1;
    #1;
    push("async_reset", 0, 0, 0, 0, 0);
    ->mon_tick;
    #1;
    step("reset_held", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("post_reset0", 32'h4, 32'h4, w(0), 1, 0);
    step("post_reset1", 32'h8, 32'h8, w(1), 1, 0);
    step("halt_again", 32'h8, 32'hC, HALT, 1, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
